map_writer: RTL and testbench

Write-side companion to the map renderer: accepts pixel-update requests (map x, y, palette index) over a valid/ready handshake, buffers them in a small FIFO, bounds-checks them and drives the write port of the dual-port 4-bit map RAM that the renderer reads. It also performs a full-map fill, for reset-to-blank or track clearing, one word per cycle. It sits between game logic (ball trail, editor input) and port B of the map RAM, in the pixel clock domain.

---
 rtl/map_writer_if.sv | 27 ++
 rtl/map_writer.sv | 201 ++++++++++++++++++++
 tb/tb_map_writer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_writer_if.sv
// Pixel-update request channel between game logic and map_writer.
// Valid/ready handshake carrying a map cell coordinate and a palette index.
interface map_writer_if #(
    parameter int unsigned PIX_W = 4
);
    logic             valid;
    logic             ready;
    logic [15:0]      x;
    logic [15:0]      y;
    logic [PIX_W-1:0] color;

    modport master (
        output valid,
        output x,
        output y,
        output color,
        input  ready
    );

    modport slave (
        input  valid,
        input  x,
        input  y,
        input  color,
        output ready
    );
endinterface

// File: rtl/map_writer.sv
// Write port driver for the 4-bit map RAM: buffers pixel-update requests, bounds-checks them,
// and performs full-map fills one word per cycle.
module map_writer #(
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned HEIGHT     = 90,
    parameter int unsigned PIX_W      = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CELLS     = WIDTH * HEIGHT,
    localparam int unsigned AW        = $clog2(CELLS)
) (
    input  logic             pixel_clk_in,
    input  logic             rst_in,
    map_writer_if.slave      req,
    input  logic             clear_in,
    input  logic [PIX_W-1:0] fill_color_in,
    output logic             we_out,
    output logic [AW-1:0]    addr_out,
    output logic [PIX_W-1:0] data_out,
    output logic             busy_out,
    output logic             clear_done_out,
    output logic [15:0]      drop_count_out
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [15:0]      x;
        logic [15:0]      y;
        logic [PIX_W-1:0] color;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e           state_q, state_d;
    entry_t           fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    entry_t           stage_q, stage_d;
    logic             stage_valid_q, stage_valid_d;
    logic             clear_pending_q, clear_pending_d;
    logic [PIX_W-1:0] fill_color_q, fill_color_d;
    logic [AW-1:0]    fill_addr_q, fill_addr_d;
    logic             last_fill_q, last_fill_d;
    logic             clear_done_q, clear_done_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [PIX_W-1:0] data_q, data_d;
    logic [15:0]      drop_q, drop_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic             push;
    logic             pop;
    logic             clear_take;
    logic             stage_oob;
    logic [AW-1:0]    stage_addr;

    assign push = req.valid && ready_q;

    // A clear seen this cycle already blocks the pop so no new entry enters the stage.
    assign clear_take = clear_in && (state_q != StClear) && !clear_pending_q;
    assign pop        = (count_q != '0) && (state_q != StClear) && !clear_pending_q && !clear_in;

    // Bounds are checked on the full 16-bit coordinates so large values cannot alias.
    assign stage_oob  = (32'(stage_q.x) >= WIDTH) || (32'(stage_q.y) >= HEIGHT);
    assign stage_addr = AW'(32'(stage_q.y) * WIDTH + 32'(stage_q.x));

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        stage_d         = stage_q;
        stage_valid_d   = 1'b0;
        clear_pending_d = clear_pending_q;
        fill_color_d    = fill_color_q;
        fill_addr_d     = fill_addr_q;
        last_fill_d     = 1'b0;
        clear_done_d    = last_fill_q;
        we_d            = 1'b0;
        addr_d          = addr_q;
        data_d          = data_q;
        drop_d          = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            stage_d       = fifo_mem[rd_ptr_q];
            stage_valid_d = 1'b1;
            rd_ptr_d      = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (clear_take) begin
            clear_pending_d = 1'b1;
            fill_color_d    = fill_color_in;
        end

        if (stage_valid_q) begin
            if (stage_oob) begin
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end else begin
                we_d   = 1'b1;
                addr_d = stage_addr;
                data_d = stage_q.color;
            end
        end

        unique case (state_q)
            StIdle, StDrain: begin
                // The stage is empty here, so fill writes never collide with a request write.
                if (clear_pending_q && !stage_valid_q) begin
                    state_d         = StClear;
                    clear_pending_d = 1'b0;
                    fill_addr_d     = '0;
                end else if ((count_d != '0) || stage_valid_d || clear_pending_d) begin
                    state_d = StDrain;
                end else begin
                    state_d = StIdle;
                end
            end
            StClear: begin
                we_d        = 1'b1;
                addr_d      = fill_addr_q;
                data_d      = fill_color_q;
                fill_addr_d = fill_addr_q + AW'(1);
                if (fill_addr_q == AW'(CELLS - 1)) begin
                    last_fill_d = 1'b1;
                    fill_addr_d = '0;
                    state_d     = (count_d != '0) ? StDrain : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = (count_d != CW'(FIFO_DEPTH));
        busy_d  = clear_pending_q || (state_q != StIdle) || (count_q != '0) || stage_valid_q;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q         <= StIdle;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            stage_q         <= '0;
            stage_valid_q   <= 1'b0;
            clear_pending_q <= 1'b0;
            fill_color_q    <= '0;
            fill_addr_q     <= '0;
            last_fill_q     <= 1'b0;
            clear_done_q    <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            drop_q          <= '0;
            ready_q         <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            stage_q         <= stage_d;
            stage_valid_q   <= stage_valid_d;
            clear_pending_q <= clear_pending_d;
            fill_color_q    <= fill_color_d;
            fill_addr_q     <= fill_addr_d;
            last_fill_q     <= last_fill_d;
            clear_done_q    <= clear_done_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            drop_q          <= drop_d;
            ready_q         <= ready_d;
            busy_q          <= busy_d;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{x: req.x, y: req.y, color: req.color};
        end
    end

    assign req.ready      = ready_q;
    assign we_out         = we_q;
    assign addr_out       = addr_q;
    assign data_out       = data_q;
    assign busy_out       = busy_q;
    assign clear_done_out = clear_done_q;
    assign drop_count_out = drop_q;
endmodule

// File: tb/tb_map_writer.sv
// Directed self-checking bench for map_writer: latency, bounds drops, bursts, full-map fill,
// reset during a fill and drop-counter saturation.
module tb_map_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  fill;
    logic        we;
    logic [13:0] addr;
    logic [3:0]  data;
    logic        busy;
    logic        done;
    logic [15:0] drop;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [13:0] wa[$];
    logic [3:0]  wd[$];
    int          wt[$];

    always #5 clk = ~clk;

    map_writer_if #(.PIX_W(4)) req_if ();

    map_writer #(
        .WIDTH      (160),
        .HEIGHT     (90),
        .PIX_W      (4),
        .FIFO_DEPTH (8)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .req            (req_if),
        .clear_in       (clear),
        .fill_color_in  (fill),
        .we_out         (we),
        .addr_out       (addr),
        .data_out       (data),
        .busy_out       (busy),
        .clear_done_out (done),
        .drop_count_out (drop)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            wa.push_back(addr);
            wd.push_back(data);
            wt.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wt.delete();
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [3:0] c,
                        output int stalls);
        int n = 0;
        req_if.valid = 1'b1;
        req_if.x     = x;
        req_if.y     = y;
        req_if.color = c;
        while (!req_if.ready && n < 20000) begin
            tick();
            n++;
        end
        stalls = n;
        if (n >= 20000) check_eq("push_timeout", 1, 0);
        else tick();
        req_if.valid = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int stall_tot;
        int n;
        int bad;
        int done_cyc;
        int dn;
        int acc;

        rst          = 1'b1;
        clear        = 1'b0;
        fill         = 4'd0;
        req_if.valid = 1'b0;
        req_if.x     = '0;
        req_if.y     = '0;
        req_if.color = '0;

        // Reset state
        tick();
        tick();
        check_eq("rst_we", we, 0);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_drop", drop, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", req_if.ready, 0);
        rst = 1'b0;
        tick();
        check_eq("ready_after_rst", req_if.ready, 1);
        check_eq("busy_after_rst", busy, 0);

        // Single write latency: x=3, y=2 -> addr 323
        clear_log();
        req_if.valid = 1'b1;
        req_if.x     = 16'd3;
        req_if.y     = 16'd2;
        req_if.color = 4'd5;
        tick();
        req_if.valid = 1'b0;
        check_eq("lat_we_k", we, 0);
        tick();
        check_eq("lat_we_k1", we, 0);
        tick();
        check_eq("lat_we_k2", we, 1);
        check_eq("lat_addr", addr, 323);
        check_eq("lat_data", data, 5);
        check_eq("lat_busy", busy, 1);
        tick();
        check_eq("lat_we_k3", we, 0);
        check_eq("lat_busy_fall", busy, 0);
        check_eq("lat_addr_hold", addr, 323);

        // Out-of-bounds drops, then the far corner
        clear_log();
        push(16'd160, 16'd0, 4'd1, st);
        push(16'd0, 16'd90, 4'd1, st);
        push(16'hFFFF, 16'd0, 4'd1, st);
        push(16'd159, 16'd89, 4'd7, st);
        repeat (6) tick();
        check_eq("oob_drop", drop, 3);
        check_eq("oob_writes", wa.size(), 1);
        if (wa.size() > 0) begin
            check_eq("corner_addr", wa[0], 14399);
            check_eq("corner_data", wd[0], 7);
        end
        check_eq("oob_busy", busy, 0);

        // Burst of 20 back-to-back requests, addr = 4i*160 + 7i = 647i
        clear_log();
        stall_tot = 0;
        for (int i = 0; i < 20; i++) begin
            push(16'(i * 7), 16'(i * 4), 4'(i), st);
            stall_tot += st;
        end
        repeat (6) tick();
        check_eq("burst_stalls", stall_tot, 0);
        check_eq("burst_count", wa.size(), 20);
        if (wa.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                check_eq($sformatf("burst_addr%0d", i), wa[i], 647 * i);
                check_eq($sformatf("burst_data%0d", i), wd[i], i % 16);
            end
            check_eq("burst_contig", wt[19] - wt[0], 19);
        end

        // Full-map fill with requests held during the sweep
        clear_log();
        fill  = 4'd2;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        fill  = 4'd9;
        stall_tot = 0;
        for (int i = 0; i < 8; i++) begin
            push(16'(10 + i), 16'd1, 4'(8 + i), st);
            stall_tot += st;
        end
        check_eq("clr_push_stalls", stall_tot, 0);
        check_eq("clr_ready_low", req_if.ready, 0);
        req_if.valid = 1'b1;
        req_if.x     = 16'd0;
        req_if.y     = 16'd0;
        req_if.color = 4'd1;
        repeat (3) tick();
        check_eq("clr_ready_still_low", req_if.ready, 0);
        req_if.valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (!done && n < 20000) begin
            tick();
            n++;
        end
        done_cyc = cyc;
        check_eq("clr_done_seen", done, 1);
        check_eq("clr_writes_at_done", wa.size(), 14400);
        if (wa.size() >= 14400) check_eq("clr_done_lag", done_cyc - wt[14399], 1);
        tick();
        check_eq("clr_done_pulse", done, 0);
        repeat (12) tick();
        check_eq("clr_total_writes", wa.size(), 14408);
        check_eq("clr_ready_back", req_if.ready, 1);
        check_eq("clr_busy_end", busy, 0);
        bad = 0;
        for (int i = 0; i < 14400 && i < wa.size(); i++) begin
            if (wa[i] != 14'(i) || wd[i] != 4'd2) bad++;
        end
        check_eq("clr_fill_bad", bad, 0);
        if (wa.size() >= 14400) check_eq("clr_fill_contig", wt[14399] - wt[0], 14399);
        for (int j = 0; j < 8; j++) begin
            if (14400 + j < wa.size()) begin
                check_eq($sformatf("held_addr%0d", j), wa[14400 + j], 170 + j);
                check_eq($sformatf("held_data%0d", j), wd[14400 + j], 8 + j);
            end
        end

        // Reset in the middle of a fill
        clear_log();
        fill  = 4'd4;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n = 0;
        while (!(we && addr == 14'd5000) && n < 20000) begin
            tick();
            n++;
        end
        check_eq("mid_fill_addr", addr, 5000);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_we", we, 0);
        check_eq("mid_rst_addr", addr, 0);
        check_eq("mid_rst_data", data, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", req_if.ready, 0);
        check_eq("mid_rst_drop", drop, 0);
        rst = 1'b0;
        tick();
        clear_log();
        dn = 0;
        repeat (100) begin
            tick();
            if (done) dn++;
        end
        check_eq("abort_no_done", dn, 0);
        check_eq("abort_no_writes", wa.size(), 0);
        push(16'd5, 16'd5, 4'd3, st);
        repeat (4) tick();
        check_eq("post_rst_count", wa.size(), 1);
        if (wa.size() > 0) begin
            check_eq("post_rst_addr", wa[0], 805);
            check_eq("post_rst_data", wd[0], 3);
        end

        // Drop counter saturation
        clear_log();
        acc = 0;
        n   = 0;
        req_if.valid = 1'b1;
        req_if.x     = 16'd200;
        req_if.y     = 16'd0;
        req_if.color = 4'd1;
        while (acc < 65537 && n < 70000) begin
            if (req_if.ready) acc++;
            tick();
            n++;
        end
        req_if.valid = 1'b0;
        repeat (6) tick();
        check_eq("sat_accepted", acc, 65537);
        check_eq("sat_drop", drop, 65535);
        check_eq("sat_no_writes", wa.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
